// File: rtl/bus_master_arbmux_pkg.sv
// Shared bus constants, arbiter state type and owner-index width helper for bus_master_arbmux.
package bus_master_arbmux_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    // Owner index width; a single bit is kept even for two masters.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_master_arbmux_pick.sv
// bus_arb_pick: combinational picker, first requester at or after start (wrapping), skipping excluded masters.
module bus_arb_pick
    import bus_master_arbmux_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     excl,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(start) + off;
            if (idx >= N) idx = idx - N;
            if (!valid && req[idx] && !excl[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_master_arbmux.sv
// Shared-bus arbiter with registered active-low grant and slave-side master mux.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module bus_master_arbmux
    import bus_master_arbmux_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int MAX_HOLD  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_MASTERS-1:0]        m_req_,
    output logic [N_MASTERS-1:0]        m_grnt_,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS-1:0]        m_as_,
    input  logic [N_MASTERS-1:0]        m_rw,
    input  logic [N_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [ADDR_W-1:0]           s_addr,
    output logic                        s_as_,
    output logic                        s_rw,
    output logic [DATA_W-1:0]           s_wr_data
);

    localparam int OWN_W  = idx_w(N_MASTERS);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_e           state, nxt_state;
    logic [OWN_W-1:0]     owner, nxt_owner;
    logic [HOLD_W-1:0]    hold_cnt, nxt_hold;
    logic [N_MASTERS-1:0] nxt_grnt;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] owner_mask;
    logic [N_MASTERS-1:0] excl;
    logic                 owner_req;
    logic                 other_req;
    logic                 forced;
    logic                 new_grant;
    logic                 pick_valid;
    logic [OWN_W-1:0]     pick_winner;
    logic [OWN_W-1:0]     start;

    assign req        = ~m_req_;
    assign owner_mask = N_MASTERS'(1) << owner;
    assign owner_req  = |(req & owner_mask);
    assign other_req  = |(req & ~owner_mask);

    // Forced release happens on the last allowed cycle only when someone else is waiting.
    assign forced = (MAX_HOLD > 0) && (state == ST_OWNED) && owner_req &&
                    (hold_cnt == HOLD_LAST) && other_req;
    assign excl   = forced ? owner_mask : '0;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [OWN_W-1:0] ptr, nxt_ptr;

    assign start   = ptr;
    assign nxt_ptr = (int'(pick_winner) == N_MASTERS - 1) ? '0 : pick_winner + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (new_grant) begin
            ptr <= nxt_ptr;
        end
    end
`else
    assign start = '0;
`endif

    bus_arb_pick #(
        .N     (N_MASTERS),
        .IDX_W (OWN_W)
    ) u_pick (
        .req    (req),
        .excl   (excl),
        .start  (start),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            hold_cnt <= '0;
            m_grnt_  <= '1;
        end else begin
            state    <= nxt_state;
            owner    <= nxt_owner;
            hold_cnt <= nxt_hold;
            m_grnt_  <= nxt_grnt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        nxt_hold  = hold_cnt;
        new_grant = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) new_grant = 1'b1;
            end
            ST_OWNED: begin
                if (owner_req && !forced) begin
                    if ((MAX_HOLD > 0) && (hold_cnt != HOLD_LAST)) nxt_hold = hold_cnt + 1'b1;
                end else if (pick_valid) begin
                    new_grant = 1'b1;
                end else begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (new_grant) begin
            nxt_state = ST_OWNED;
            nxt_owner = pick_winner;
            nxt_hold  = '0;
        end
        nxt_grnt = (nxt_state == ST_OWNED) ? ~(N_MASTERS'(1) << nxt_owner) : '1;
    end

    // Slave-side mux: only the registered owner can drive the shared bus.
    always_comb begin
        s_addr    = '0;
        s_as_     = DISABLE_;
        s_rw      = READ;
        s_wr_data = '0;
        if (state == ST_OWNED) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (owner == OWN_W'(i)) begin
                    s_addr    = m_addr[i*ADDR_W +: ADDR_W];
                    s_as_     = m_as_[i];
                    s_rw      = m_rw[i];
                    s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
